// File: rtl/pwm_pkg.sv
// Shared PWM constants, width helper and duty type.
// The FND decoder and the motor top use these as well.
package pwm_pkg;

  localparam int unsigned PWM_DEFAULT_PERIOD   = 100;
  localparam int unsigned PWM_DEFAULT_PRESCALE = 10;

  // Number of bits needed to encode the values 0 .. v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned PWM_DEFAULT_DW = clog2(PWM_DEFAULT_PERIOD + 1);

  typedef logic [PWM_DEFAULT_DW-1:0] duty_t;

endpackage

// File: rtl/pwm_duty_setpoint.sv
// One channel's button edge detection, saturating setpoint and applied-duty register.
// The applied duty moves only on the period wrap so that no pulse is cut short.
module pwm_duty_setpoint
  import pwm_pkg::*;
#(
  parameter int unsigned DW        = 7,
  parameter int unsigned DUTY_MIN  = 10,
  parameter int unsigned DUTY_MAX  = 90,
  parameter int unsigned DUTY_INIT = 50,
  parameter int unsigned DUTY_STEP = 10,
  parameter int unsigned RAMP_STEP = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  input  logic          wrap,
  input  logic          enable,
  output logic [DW-1:0] target,
  output logic [DW-1:0] applied
);

  localparam int unsigned DEC_FLOOR = DUTY_MIN + DUTY_STEP;

  logic          prev_inc;
  logic          prev_dec;
  logic          inc_edge;
  logic          dec_edge;
  logic [DW:0]   up_sum;
  logic [DW-1:0] gap;
  logic [DW-1:0] target_next;
  logic [DW-1:0] applied_next;

  // Saturating setpoint step; simultaneous edges cancel.
  always_comb begin
    inc_edge    = inc & ~prev_inc;
    dec_edge    = dec & ~prev_dec;
    up_sum      = {1'b0, target} + (DW+1)'(DUTY_STEP);
    target_next = target;
    if (inc_edge && !dec_edge) begin
      target_next = (up_sum > (DW+1)'(DUTY_MAX)) ? DW'(DUTY_MAX) : up_sum[DW-1:0];
    end else if (dec_edge && !inc_edge) begin
      target_next = ({1'b0, target} >= (DW+1)'(DEC_FLOOR)) ? target - DW'(DUTY_STEP)
                                                            : DW'(DUTY_MIN);
    end
  end

  // Slew toward the setpoint, or fall to zero while disabled.
  always_comb begin
    gap          = (target > applied) ? target - applied : applied - target;
    applied_next = applied;
    if (!enable) begin
      applied_next = '0;
    end else if (RAMP_STEP == 0) begin
      applied_next = target;
    end else if (target > applied) begin
      applied_next = applied + ((gap > DW'(RAMP_STEP)) ? DW'(RAMP_STEP) : gap);
    end else begin
      applied_next = applied - ((gap > DW'(RAMP_STEP)) ? DW'(RAMP_STEP) : gap);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_inc <= 1'b0;
      prev_dec <= 1'b0;
      target   <= DW'(DUTY_INIT);
      applied  <= '0;
    end else begin
      prev_inc <= inc;
      prev_dec <= dec;
      target   <= target_next;
      if (wrap) applied <= applied_next;
    end
  end

endmodule

// File: rtl/pwm_multi_duty_ctrl.sv
// N-channel PWM generator: shared prescaler and period counter, per-channel setpoints,
// registered compare outputs.
module pwm_multi_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PERIOD    = PWM_DEFAULT_PERIOD,
  parameter int unsigned PRESCALE  = PWM_DEFAULT_PRESCALE,
  parameter int unsigned DUTY_MIN  = 10,
  parameter int unsigned DUTY_MAX  = 90,
  parameter int unsigned DUTY_INIT = 50,
  parameter int unsigned DUTY_STEP = 10,
  parameter int unsigned RAMP_STEP = 0,
  localparam int unsigned DW       = clog2(PERIOD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    duty_inc,
  input  logic [NUM_CH-1:0]    duty_dec,
  output logic [NUM_CH*DW-1:0] duty_target,
  output logic [NUM_CH*DW-1:0] duty_applied,
  output logic                 period_start,
  output logic [NUM_CH-1:0]    pwm_out
);

  localparam int unsigned PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic [DW-1:0] cnt;
  logic          tick;
  logic          wrap;
  logic [DW-1:0] applied_ch [NUM_CH];

  always_comb begin
    tick = (presc == PW'(PRESCALE - 1));
    wrap = tick && (cnt == DW'(PERIOD - 1));
  end

  // Prescaler and period counter keep running regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + PW'(1);
      period_start <= wrap;
      if (wrap)      cnt <= '0;
      else if (tick) cnt <= cnt + DW'(1);
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    pwm_duty_setpoint #(
      .DW        (DW),
      .DUTY_MIN  (DUTY_MIN),
      .DUTY_MAX  (DUTY_MAX),
      .DUTY_INIT (DUTY_INIT),
      .DUTY_STEP (DUTY_STEP),
      .RAMP_STEP (RAMP_STEP)
    ) u_setpoint (
      .clk     (clk),
      .reset   (reset),
      .inc     (duty_inc[i]),
      .dec     (duty_dec[i]),
      .wrap    (wrap),
      .enable  (enable),
      .target  (duty_target[i*DW +: DW]),
      .applied (applied_ch[i])
    );
    assign duty_applied[i*DW +: DW] = applied_ch[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        pwm_out[i] <= enable & (cnt < applied_ch[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_duty_ctrl.sv
// Two PWM instances (fast/no-ramp and prescaled/ramped) checked every cycle against
// a counting-based model, plus hand-computed anchor values.
module tb_pwm_multi_duty_ctrl;

  localparam int PER = 10;
  localparam int DW  = 4;
  localparam int PS [2] = '{1, 4};
  localparam int MN [2] = '{1, 2};
  localparam int MX [2] = '{9, 10};
  localparam int IN [2] = '{5, 8};
  localparam int ST [2] = '{1, 3};
  localparam int RP [2] = '{0, 2};
  localparam int EXP_INC [6] = '{6, 7, 8, 9, 9, 9};
  localparam int EXP_RAMP [5] = '{2, 4, 6, 8, 10};

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] inc;
  logic [1:0] dec;
  logic [7:0] tgt_a, app_a, tgt_b, app_b;
  logic       ps_a, ps_b;
  logic [1:0] pwm_a, pwm_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_multi_duty_ctrl #(
    .NUM_CH(2), .PERIOD(PER), .PRESCALE(PS[0]), .DUTY_MIN(MN[0]), .DUTY_MAX(MX[0]),
    .DUTY_INIT(IN[0]), .DUTY_STEP(ST[0]), .RAMP_STEP(RP[0])
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .duty_inc(inc), .duty_dec(dec),
    .duty_target(tgt_a), .duty_applied(app_a), .period_start(ps_a), .pwm_out(pwm_a)
  );

  pwm_multi_duty_ctrl #(
    .NUM_CH(2), .PERIOD(PER), .PRESCALE(PS[1]), .DUTY_MIN(MN[1]), .DUTY_MAX(MX[1]),
    .DUTY_INIT(IN[1]), .DUTY_STEP(ST[1]), .RAMP_STEP(RP[1])
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .duty_inc(inc), .duty_dec(dec),
    .duty_target(tgt_b), .duty_applied(app_b), .period_start(ps_b), .pwm_out(pwm_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: timing derived from the number of clock edges since reset.
  int   m_edges;
  int   m_tgt [2][2];
  int   m_app [2][2];
  logic m_pwm [2][2];
  logic m_ps  [2];
  logic [1:0] m_pinc, m_pdec;
  int   m_cnt;
  bit   m_wrap;

  function automatic int sat_step(input int t, input bit ie, input bit de, input int k);
    if (ie && !de) return (t + ST[k] > MX[k]) ? MX[k] : t + ST[k];
    if (de && !ie) return (t - ST[k] < MN[k]) ? MN[k] : t - ST[k];
    return t;
  endfunction

  function automatic int approach(input int t, input int a, input int r);
    if (r == 0) return t;
    if (t > a)  return a + (((t - a) < r) ? (t - a) : r);
    return a - (((a - t) < r) ? (a - t) : r);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0;
      m_pinc  = '0;
      m_pdec  = '0;
      for (int k = 0; k < 2; k++) begin
        m_ps[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_tgt[k][i] = IN[k];
          m_app[k][i] = 0;
          m_pwm[k][i] = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_cnt   = (m_edges / PS[k]) % PER;
        m_wrap  = ((m_edges + 1) % (PS[k] * PER)) == 0;
        m_ps[k] = m_wrap;
        for (int i = 0; i < 2; i++) begin
          m_pwm[k][i] = enable && (m_cnt < m_app[k][i]);
          if (m_wrap) m_app[k][i] = enable ? approach(m_tgt[k][i], m_app[k][i], RP[k]) : 0;
          m_tgt[k][i] = sat_step(m_tgt[k][i], inc[i] & ~m_pinc[i], dec[i] & ~m_pdec[i], k);
        end
      end
      m_pinc = inc;
      m_pdec = dec;
      m_edges++;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("ps_a", 32'(ps_a), 32'(m_ps[0]));
    check("ps_b", 32'(ps_b), 32'(m_ps[1]));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pwm_a[%0d]", i), 32'(pwm_a[i]), 32'(m_pwm[0][i]));
      check($sformatf("pwm_b[%0d]", i), 32'(pwm_b[i]), 32'(m_pwm[1][i]));
      check($sformatf("tgt_a[%0d]", i), 32'(tgt_a[i*DW +: DW]), 32'(m_tgt[0][i]));
      check($sformatf("tgt_b[%0d]", i), 32'(tgt_b[i*DW +: DW]), 32'(m_tgt[1][i]));
      check($sformatf("app_a[%0d]", i), 32'(app_a[i*DW +: DW]), 32'(m_app[0][i]));
      check($sformatf("app_b[%0d]", i), 32'(app_b[i*DW +: DW]), 32'(m_app[1][i]));
    end
  end

  task automatic wait_ps_b();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ps_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_ps_b", 32'(ok), 32'd1);
  endtask

  initial begin
    int hi;
    int gap;
    bit seen;
    reset  = 1'b1;
    enable = 1'b1;
    inc    = '0;
    dec    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("a_tgt0_init", 32'(tgt_a[3:0]), 32'd5);
    check("b_tgt0_init", 32'(tgt_b[3:0]), 32'd8);
    check("a_app0_init", 32'(app_a[3:0]), 32'd0);

    // Steady state at INIT: 5 of every 10 clocks high.
    repeat (25) @(negedge clk);
    hi = 0;
    repeat (10) begin @(negedge clk); hi += int'(pwm_a[0]); end
    check("a_width_init", 32'(hi), 32'd5);

    for (int n = 0; n < 6; n++) begin
      @(negedge clk); inc = 2'b01;
      @(negedge clk); inc = 2'b00;
      check("a_tgt0_inc", 32'(tgt_a[3:0]), 32'(EXP_INC[n]));
    end

    @(negedge clk); inc = 2'b10; dec = 2'b10;
    @(negedge clk); inc = 2'b00; dec = 2'b00;
    check("a_tgt1_both", 32'(tgt_a[7:4]), 32'd5);
    @(negedge clk); inc = 2'b10;
    repeat (5) @(negedge clk);
    inc = 2'b00;
    @(negedge clk);
    check("a_tgt1_held", 32'(tgt_a[7:4]), 32'd6);

    // Prescaled instance: one period_start every PRESCALE*PERIOD clocks.
    wait_ps_b();
    gap = 0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      gap++;
      seen = ps_b;
    end
    check("b_period_clk", 32'(gap), 32'd40);

    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("a_pwm_disabled", 32'(pwm_a), 32'd0);
    check("b_pwm_disabled", 32'(pwm_b), 32'd0);
    repeat (50) @(negedge clk);
    check("b_app0_cleared", 32'(app_b[3:0]), 32'd0);

    // Soft start from 0 toward target 10 in steps of 2.
    enable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_ps_b();
      check("b_app0_ramp", 32'(app_b[3:0]), 32'(EXP_RAMP[n]));
    end
    hi = 0;
    repeat (40) begin @(negedge clk); hi += int'(pwm_b[0]); end
    check("b_width_full", 32'(hi), 32'd40);

    // Reset in the middle of a high pulse.
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = pwm_a[0];
    end
    check("a_pwm_high_seen", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("a_pwm_in_reset", 32'(pwm_a), 32'd0);
    check("a_app0_in_reset", 32'(app_a[3:0]), 32'd0);
    @(negedge clk); reset = 1'b0;
    check("a_tgt0_after_reset", 32'(tgt_a[3:0]), 32'd5);
    hi = 0;
    repeat (9) begin @(negedge clk); hi += int'(pwm_a[0]); end
    check("a_no_pulse_after_reset", 32'(hi), 32'd0);

    // Randomized phase; the every-cycle comparison does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        inc = 2'($urandom);
        dec = 2'($urandom);
      end
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
